// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD geometry, mode encodings and write-queue entry types
package lcd_pkg;

  localparam int LCD_W        = 160;
  localparam int LCD_H        = 144;
  localparam int FRAME_PIXELS = LCD_W * LCD_H;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 15;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'b00,
    MODE_VBLANK = 2'b01,
    MODE_OAM    = 2'b10,
    MODE_XFER   = 2'b11
  } lcd_mode_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_t;

endpackage

// File: rtl/lcd_wr_fifo.sv
// rtl/lcd_wr_fifo.sv - small register FIFO holding pending frame-buffer writes for one source
module lcd_wr_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the same cycle frees a slot.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lcd_wr_arbiter.sv
// rtl/lcd_wr_arbiter.sv - round-robin merge of two LCD pixel streams onto one frame-buffer write port
module lcd_wr_arbiter #(
  parameter int DATA_W       = 15,
  parameter int ADDR_W       = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = lcd_pkg::FRAME_PIXELS,
  parameter int BASE2        = 23040
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce1,
  input  logic [DATA_W-1:0] data1,
  input  logic [1:0]        mode1,
  input  logic              on1,
  input  logic              ce2,
  input  logic [DATA_W-1:0] data2,
  input  logic [1:0]        mode2,
  input  logic              on2,
  input  logic              clr_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done1,
  output logic              frame_done2,
  output logic              ovf1,
  output logic              ovf2
);

  import lcd_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] FRAME_LEN = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] BASE2_A   = ADDR_W'(BASE2);
  localparam logic [ADDR_W-1:0] LAST1     = FRAME_LEN - 1'b1;
  localparam logic [ADDR_W-1:0] LAST2     = BASE2_A + FRAME_LEN - 1'b1;
  localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] ptr1_q, ptr1_d, ptr2_q, ptr2_d;
  logic              ovf1_q, ovf1_d, ovf2_q, ovf2_d;
  src_t              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              frame_done1_q, frame_done1_d, frame_done2_q, frame_done2_d;

  logic              rst1, rst2, take1, take2;
  logic              push1, push2, pop1, pop2, drop1, drop2;
  logic              full1, full2, empty1, empty2;
  logic [CW-1:0]     count1, count2;
  logic [EW-1:0]     entry1, entry2, head1, head2;

  lcd_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(reset_n), .push(push1), .push_data(entry1), .pop(pop1),
    .pop_data(head1), .full(full1), .empty(empty1), .count(count1)
  );

  lcd_wr_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk(clk), .rst_n(reset_n), .push(push2), .push_data(entry2), .pop(pop2),
    .pop_data(head2), .full(full2), .empty(empty2), .count(count2)
  );

  // Source 2 wins only when source 1 has nothing or got the previous slot.
  always_comb begin
    rst1   = !on1 || (mode1 == MODE_VBLANK);
    rst2   = !on2 || (mode2 == MODE_VBLANK);
    take1  = ce1 && !rst1 && (ptr1_q < FRAME_LEN);
    take2  = ce2 && !rst2 && (ptr2_q < FRAME_LEN);
    pop2   = !empty2 && (empty1 || (last_grant_q == SRC1));
    pop1   = !empty1 && !pop2;
    push1  = take1 && (!full1 || pop1);
    push2  = take2 && (!full2 || pop2);
    drop1  = take1 && (count1 == DEPTH_C) && !pop1;
    drop2  = take2 && (count2 == DEPTH_C) && !pop2;
    entry1 = {ptr1_q, data1};
    entry2 = {BASE2_A + ptr2_q, data2};
  end

  // Dropped pixels still advance the pointer so later pixels land at their true position.
  always_comb begin
    ptr1_d        = rst1 ? '0 : (take1 ? ptr1_q + 1'b1 : ptr1_q);
    ptr2_d        = rst2 ? '0 : (take2 ? ptr2_q + 1'b1 : ptr2_q);
    ovf1_d        = drop1 || (ovf1_q && !clr_ovf);
    ovf2_d        = drop2 || (ovf2_q && !clr_ovf);
    last_grant_d  = last_grant_q;
    wr_en_d       = pop1 || pop2;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done1_d = pop1 && (head1[EW-1 -: ADDR_W] == LAST1);
    frame_done2_d = pop2 && (head2[EW-1 -: ADDR_W] == LAST2);
    if (pop1) begin
      last_grant_d           = SRC1;
      {wr_addr_d, wr_data_d} = head1;
    end else if (pop2) begin
      last_grant_d           = SRC2;
      {wr_addr_d, wr_data_d} = head2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr1_q        <= '0;
      ptr2_q        <= '0;
      ovf1_q        <= 1'b0;
      ovf2_q        <= 1'b0;
      last_grant_q  <= SRC2;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done1_q <= 1'b0;
      frame_done2_q <= 1'b0;
    end else begin
      ptr1_q        <= ptr1_d;
      ptr2_q        <= ptr2_d;
      ovf1_q        <= ovf1_d;
      ovf2_q        <= ovf2_d;
      last_grant_q  <= last_grant_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done1_q <= frame_done1_d;
      frame_done2_q <= frame_done2_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done1 = frame_done1_q;
  assign frame_done2 = frame_done2_q;
  assign ovf1        = ovf1_q;
  assign ovf2        = ovf2_q;

endmodule

// File: tb/tb_lcd_wr_arbiter.sv
// tb/tb_lcd_wr_arbiter.sv - scoreboard bench for the two-source frame-buffer write arbiter
module tb_lcd_wr_arbiter;
  import lcd_pkg::*;

  localparam int FP = 23040;
  localparam int B2 = 23040;

  typedef struct {
    fifo_entry_t ent;
    logic        fd1;
    logic        fd2;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce1 = 1'b0, ce2 = 1'b0, on1 = 1'b1, on2 = 1'b1, clr_ovf = 1'b0;
  logic [14:0] data1 = '0, data2 = '0;
  logic [1:0]  mode1 = 2'b00, mode2 = 2'b00;
  logic        wr_en, frame_done1, frame_done2, ovf1, ovf2;
  logic [15:0] wr_addr;
  logic [14:0] wr_data;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   fd1_seen = 0;

  lcd_wr_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .ce1(ce1), .data1(data1), .mode1(mode1), .on1(on1),
    .ce2(ce2), .data2(data2), .mode2(mode2), .on2(on2),
    .clr_ovf(clr_ovf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done1(frame_done1), .frame_done2(frame_done2),
    .ovf1(ovf1), .ovf2(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_writes++;
      if (frame_done1 === 1'b1) fd1_seen++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h at cyc %0d, required no write", wr_addr, wr_data, cyc);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.ent.addr || wr_data !== e.ent.data || frame_done1 !== e.fd1 ||
            frame_done2 !== e.fd2 || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL write: addr=%0d data=%h fd=%b%b cyc=%0d, required addr=%0d data=%h fd=%b%b cyc=%0d",
                   wr_addr, wr_data, frame_done1, frame_done2, cyc, e.ent.addr, e.ent.data, e.fd1, e.fd2, e.cyc);
        end
      end
    end else begin
      n_checks++;
      if (frame_done1 !== 1'b0 || frame_done2 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_frame_done: fd=%b%b at cyc %0d, required 00", frame_done1, frame_done2, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [14:0] d, input int c);
    exp_t x;
    x.ent.addr = a;
    x.ent.data = d;
    x.fd1 = (a == 16'(FP - 1));
    x.fd2 = (a == 16'(B2 + FP - 1));
    x.cyc = c;
    sb.push_back(x);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    repeat (4) tick();
  endtask

  task automatic do_reset();
    ce1 = 1'b0; ce2 = 1'b0; clr_ovf = 1'b0;
    on1 = 1'b1; on2 = 1'b1; mode1 = 2'b00; mode2 = 2'b00;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({wr_en, frame_done1, frame_done2, ovf1, ovf2} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00000", {wr_en, frame_done1, frame_done2, ovf1, ovf2});
    end
    n_checks++;
    if (wr_addr !== 16'd0 || wr_data !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_port: addr=%0d data=%h, required 0 0", wr_addr, wr_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [14:0] pix [3];
    pix[0] = 15'h7FFF; pix[1] = 15'h001F; pix[2] = 15'h03E0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ce1 = 1'b1; data1 = pix[i];
      push_exp(16'(i), pix[i], cyc + 2);
      tick();
      ce1 = 1'b0;
      repeat (2) tick();
    end
    wait_drain();
    n_checks++;
    if (sb.size() != 0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: pending=%0d ovf1=%b, required 0 0", sb.size(), ovf1);
      sb.delete();
    end
  endtask

  task automatic test_contention();
    int k0;
    do_reset();
    k0 = cyc;
    for (int i = 0; i < 3; i++) begin
      ce1 = 1'b1; ce2 = 1'b1;
      data1 = 15'h1000 + 15'(i); data2 = 15'h2000 + 15'(i);
      push_exp(16'(i), data1, k0 + 2 + 2 * i);
      push_exp(16'(B2 + i), data2, k0 + 3 + 2 * i);
      tick();
    end
    ce1 = 1'b0; ce2 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL contention_end: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_overflow();
    int k0;
    int acc1 [10];
    int acc2 [9];
    acc1 = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};
    acc2 = '{0, 1, 2, 3, 4, 5, 6, 8, 10};
    do_reset();
    k0 = cyc;
    for (int j = 0; j < 19; j++) begin
      if (j % 2 == 0) push_exp(16'(acc1[j/2]), 15'h100 + 15'(acc1[j/2]), k0 + 2 + j);
      else            push_exp(16'(B2 + acc2[j/2]), 15'h200 + 15'(acc2[j/2]), k0 + 2 + j);
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        n_checks++;
        if (ovf1 !== 1'b0 || ovf2 !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_first_drop: ovf1=%b ovf2=%b, required 0 1", ovf1, ovf2);
        end
      end
      if (i == 9) begin
        n_checks++;
        if (ovf1 !== 1'b1 || ovf2 !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_clr_vs_set: ovf1=%b ovf2=%b, required 1 0", ovf1, ovf2);
        end
      end
      ce1 = 1'b1; ce2 = 1'b1;
      data1 = 15'h100 + 15'(i); data2 = 15'h200 + 15'(i);
      clr_ovf = (i == 8);
      tick();
    end
    ce1 = 1'b0; ce2 = 1'b0; clr_ovf = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0 || ovf1 !== 1'b1 || ovf2 !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_burst_end: pending=%0d ovf1=%b ovf2=%b, required 0 1 1", sb.size(), ovf1, ovf2);
      sb.delete();
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_idle_clear: ovf1=%b ovf2=%b, required 0 0", ovf1, ovf2);
    end
    ce1 = 1'b1; data1 = 15'h155;
    push_exp(16'd12, 15'h155, cyc + 2);
    tick();
    ce1 = 1'b0;
    tick();
    ce2 = 1'b1; data2 = 15'h2AA;
    push_exp(16'(B2 + 12), 15'h2AA, cyc + 2);
    tick();
    ce2 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_resume: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_restart();
    do_reset();
    for (int i = 0; i < 98; i++) begin
      ce1 = 1'b1; data1 = 15'(i * 11);
      push_exp(16'(i), data1, cyc + 2);
      tick();
    end
    ce1 = 1'b1; data1 = 15'(98 * 11); ce2 = 1'b1; data2 = 15'h0AA;
    push_exp(16'(B2), 15'h0AA, -1);
    push_exp(16'd98, 15'(98 * 11), -1);
    tick();
    ce1 = 1'b1; data1 = 15'(99 * 11); ce2 = 1'b1; data2 = 15'h0BB;
    push_exp(16'(B2 + 1), 15'h0BB, -1);
    push_exp(16'd99, 15'(99 * 11), -1);
    tick();
    mode1 = 2'b01; ce1 = 1'b1; data1 = 15'h7777; ce2 = 1'b0;
    tick();
    mode1 = 2'b00; ce1 = 1'b0;
    wait_drain();
    ce1 = 1'b1; data1 = 15'h4321;
    push_exp(16'd0, 15'h4321, cyc + 2);
    tick();
    ce1 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_end: pending=%0d ovf1=%b, required 0 0", sb.size(), ovf1);
      sb.delete();
    end
  endtask

  task automatic test_frame_end();
    int fd_before;
    do_reset();
    fd_before = fd1_seen;
    for (int i = 0; i < FP + 1; i++) begin
      ce1 = 1'b1; data1 = 15'(i * 3);
      if (i < FP) push_exp(16'(i), data1, cyc + 2);
      tick();
    end
    ce1 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0 || ovf1 !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end: pending=%0d ovf1=%b, required 0 0", sb.size(), ovf1);
      sb.delete();
    end
    n_checks++;
    if (fd1_seen - fd_before != 1) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d pulses, required 1", fd1_seen - fd_before);
    end
  endtask

  task automatic test_reset_flush();
    int w_before;
    do_reset();
    ce1 = 1'b1; ce2 = 1'b1; data1 = 15'h0111; data2 = 15'h0222;
    push_exp(16'd0, 15'h0111, cyc + 2);
    tick();
    data1 = 15'h0333; data2 = 15'h0444;
    tick();
    ce1 = 1'b0; ce2 = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: wr_en=%b, required 0", wr_en);
    end
    w_before = n_writes;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (n_writes != w_before || sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_flush: writes=%0d pending=%0d, required 0 0", n_writes - w_before, sb.size());
      sb.delete();
    end
    ce1 = 1'b1; data1 = 15'h0555;
    push_exp(16'd0, 15'h0555, cyc + 2);
    tick();
    ce1 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_first_write: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_disable();
    int w_before;
    do_reset();
    w_before = n_writes;
    on2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ce2 = 1'b1; data2 = 15'h0600 + 15'(i);
      tick();
    end
    ce2 = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (n_writes != w_before) begin
      n_fail++;
      $display("FAIL disable_no_write: writes=%0d, required 0", n_writes - w_before);
    end
    on2 = 1'b1;
    ce2 = 1'b1; data2 = 15'h0777;
    push_exp(16'(B2), 15'h0777, cyc + 2);
    tick();
    ce2 = 1'b0;
    wait_drain();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL disable_reenable: pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_restart();
    test_frame_end();
    test_reset_flush();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_wr_arbiter.md
Name: lcd_wr_arbiter

Overview:
- Shares one frame-buffer write port between the two Game Boy core pixel streams (linked-pair mode).
- Each source gets its own small FIFO, a frame pointer and a fixed base region in a combined 2-frame buffer.
- A round-robin scheduler drains the FIFOs into a single registered write port.
- Sits between the two cores' LCD outputs and the video frame buffer RAM read by the scan-out logic.

Parameters:
- DATA_W, 15, pixel width (RGB555 or 2-bit DMG index in LSBs).
- ADDR_W, 16, write address width (covers 2 x FRAME_PIXELS).
- FIFO_DEPTH, 4, entries per source FIFO; power of two, >= 2.
- FRAME_PIXELS, 23040, pixels per frame (160 x 144).
- BASE2, 23040, address base of the source-2 region; source-1 base is 0.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce1  in  1  source-1 pixel strobe.
- data1  in  DATA_W  source-1 pixel.
- mode1  in  2  source-1 LCD mode (01 = vblank).
- on1  in  1  source-1 LCD enable.
- ce2, data2, mode2, on2  in  1/DATA_W/2/1  same signals for source 2.
- clr_ovf  in  1  clears both overflow flags.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- frame_done1, frame_done2  out  1  one-cycle pulse when the last pixel of a frame is written.
- ovf1, ovf2  out  1  sticky flag: a pixel was dropped because the FIFO was full.

Behaviour:
- Reset (async, reset_n=0):
  - wr_en, wr_addr, wr_data, frame_done*, ovf* = 0.
  - ptr1 = ptr2 = 0; both FIFOs empty.
  - last_grant = source 2, so source 1 wins the first tie.
  - Reset asserted mid-frame discards all queued pixels.
- Restart, per source i: rst_i = !on_i || mode_i==01.
  - While rst_i is high, ptr_i <= 0 and ce_i is ignored. Restart has priority over ce_i.
  - Entries already queued are still written at their stored addresses.
- Enqueue: when ce_i && !rst_i.
  - If ptr_i < FRAME_PIXELS: push {BASE_i+ptr_i, data_i} and ptr_i++.
  - Full FIFO (count==FIFO_DEPTH and no pop that cycle): pixel dropped, ptr_i still increments (frame geometry preserved), ovf_i <= 1.
  - Push into a full FIFO in the same cycle as a pop from it is accepted; count is unchanged.
  - If ptr_i == FRAME_PIXELS: pixel dropped, ptr_i holds, ovf_i unchanged (surplus pixels are not an error).
- Address arithmetic: BASE_i + ptr_i computed at enqueue in ADDR_W bits; never wraps within a region.
- Scheduler, every cycle:
  - Exactly one FIFO non-empty: pop it.
  - Both non-empty: pop the source != last_grant.
  - last_grant updates only on a pop.
  - No pop: wr_en <= 0; wr_addr and wr_data hold their last values.
- Output register: on a pop, wr_en <= 1 and wr_addr/wr_data <= head entry. frame_done_i <= 1 in the same cycle when the popped address == BASE_i+FRAME_PIXELS-1.
- Latency: ce sampled at edge N → FIFO head valid after N → popped at edge N+1 → wr_en high during the cycle after edge N+1 (2 edges). Minimum spacing is 1 write per cycle.
- Overflow flags: clr_ovf clears both. A set event in the same cycle as clr_ovf wins (flag stays 1).
- Sustained throughput: the port supports 1 pixel/cycle combined. Both sources strobing every cycle overflow by design.

Decomposition:
- Package lcd_pkg:
  - LCD_W=160, LCD_H=144, FRAME_PIXELS.
  - MODE_HBLANK/MODE_VBLANK/MODE_OAM/MODE_XFER encodings.
  - A fifo_entry_t typedef {addr, data}.
- Sub-module lcd_wr_fifo:
  - Synchronous register FIFO with push/pop/full/empty/count.
  - Instantiated twice, one per source.
- Pointer, restart, arbitration and output logic stay in lcd_wr_arbiter.

Test Plan:
- Single source: on1=1, mode1=00, ce1 pulses with data 7FFF, 001F, 03E0 at edges 10, 13, 16 → wr_en at the cycles after edges 12, 15, 18 with addr 0, 1, 2 and matching data; ovf1=0.
- Contention: ce1 and ce2 high for 3 consecutive cycles from empty → writes alternate 0, 23040, 1, 23041, 2, 23042; wr_en continuous for 6 cycles.
- Overflow: ce1 and ce2 high for 12 cycles, FIFO_DEPTH=4 → ovf1=ovf2=1. Dropped pixels are never written; the next accepted pixel's addr equals enqueue count (ptr advanced past drops). clr_ovf asserted during an active drop leaves the flag set; asserted idle clears it.
- Restart: after 100 source-1 pixels, mode1=01 for 1 cycle while 2 entries are queued → the queued addrs 98, 99 are still written. The next pixel goes to addr 0.
- Frame end: 23041 source-1 pixels → frame_done1 pulses exactly with wr_addr 23039; the 23041st pixel produces no write; ovf1=0.
- Reset and disable: reset_n=0 with 3 queued entries → wr_en=0 immediately and no write after release; first new write addr 0. With on2=0, ce2 pulses → no writes.
